// File: rtl/wb_burst_master_if.sv
// wb_burst_master_if: Wishbone classic bus between the burst master and its slave
interface wb_burst_master_if #(parameter int dw = 32, parameter int aw = 26);
  logic wb_cyc_o;
  logic wb_stb_o;
  logic wb_we_o;
  logic wb_ack_i;
  logic [aw-1:0] wb_addr_o;
  logic [dw-1:0] wb_dat_o;
  logic [dw-1:0] wb_dat_i;
  logic [dw/8-1:0] wb_sel_o;
  modport master(output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, input wb_ack_i, wb_dat_i);
  modport slave(input wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, output wb_ack_i, wb_dat_i);
endinterface

// File: rtl/wb_burst_master.sv
// wb_burst_master: command-driven Wishbone burst master; ACK timeout abort built when WB_MST_TIMEOUT_EN is defined
module wb_burst_master #(
  parameter int dw = 32,
  parameter int aw = 26,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic wb_clk_i,
  input  logic RESETN,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_we,
  input  logic [aw-1:0] cmd_addr,
  input  logic [7:0] cmd_len,
  input  logic wdat_valid,
  output logic wdat_ready,
  input  logic [dw-1:0] wdat,
  input  logic [dw/8-1:0] wdat_sel,
  output logic rdat_valid,
  output logic [dw-1:0] rdat,
  output logic rdat_last,
  output logic busy,
  output logic err,
  wb_burst_master_if.master wb
);
  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
  state_t state, state_nx;
  logic we_r, hr_v, hr_v_nx, accept, ack, last, wtake, abort;
  logic [aw-1:0] addr_r;
  logic [8:0] beats_left, load_left, len1;
  logic [dw-1:0] hr_d;
  logic [dw/8-1:0] hr_s;
  assign len1 = cmd_len == 8'd0 ? 9'd1 : {1'b0, cmd_len};
  assign accept = state == IDLE && cmd_valid;
  assign ack = wb.wb_ack_i && state == RUN;
  assign last = ack && beats_left == 9'd1;
  // the first write word is taken together with its command so STB can rise on the next cycle
  assign wdat_ready = state == IDLE ? cmd_valid && cmd_we
                    : we_r && (state == RUN || state == GAP) && load_left != 9'd0 && (!hr_v || ack);
  assign wtake = wdat_ready && wdat_valid;
  assign hr_v_nx = wtake || (hr_v && !ack);
`ifdef WB_MST_TIMEOUT_EN
  localparam int tw = $clog2(TIMEOUT_CYC + 1);
  logic [tw-1:0] tmo;
  logic ack_wait;
  assign ack_wait = state == RUN && !wb.wb_ack_i;
  assign abort = ack_wait && tmo == tw'(TIMEOUT_CYC - 1);
  always_ff @(posedge wb_clk_i or negedge RESETN)
    if (!RESETN) begin
      tmo <= '0;
      err <= 1'b0;
    end else begin
      tmo <= ack_wait ? tmo + 1'b1 : '0;
      err <= abort;
    end
`else
  assign abort = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge wb_clk_i or negedge RESETN)
    if (!RESETN) begin
      state <= IDLE;
      we_r <= 1'b0;
      addr_r <= '0;
      beats_left <= '0;
      load_left <= '0;
      hr_v <= 1'b0;
      hr_d <= '0;
      hr_s <= '0;
      rdat_valid <= 1'b0;
      rdat <= '0;
      rdat_last <= 1'b0;
    end else begin
      state <= state_nx;
      rdat_valid <= ack && !we_r;
      rdat_last <= last && !we_r;
      if (ack && !we_r) rdat <= wb.wb_dat_i;
      if (accept) begin
        we_r <= cmd_we;
        addr_r <= cmd_addr & ~aw'(dw / 8 - 1);
        beats_left <= len1;
        load_left <= len1 - 9'(wtake);
      end else begin
        if (ack) addr_r <= addr_r + aw'(dw / 8);
        if (ack) beats_left <= beats_left - 9'd1;
        if (wtake) load_left <= load_left - 9'd1;
      end
      hr_v <= abort ? 1'b0 : hr_v_nx;
      if (wtake) hr_d <= wdat;
      if (wtake) hr_s <= wdat_sel;
    end
  always_comb begin
    state_nx = state;
    cmd_ready = state == IDLE;
    busy = state != IDLE;
    wb.wb_cyc_o = state == RUN || state == GAP;
    wb.wb_stb_o = state == RUN;
    wb.wb_we_o = we_r && wb.wb_cyc_o;
    wb.wb_addr_o = addr_r;
    wb.wb_dat_o = hr_d;
    wb.wb_sel_o = wb.wb_cyc_o && !we_r ? '1 : hr_s;
    case (state)
      IDLE: if (accept) state_nx = cmd_we && !wdat_valid ? GAP : RUN;
      RUN: state_nx = last || abort ? DONE : we_r && !hr_v_nx ? GAP : RUN;
      GAP: if (hr_v_nx) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: scoreboard bench for the Wishbone burst master
module tb_wb_burst_master;
  localparam int dw = 32;
  localparam int aw = 26;
`ifdef WB_MST_TIMEOUT_EN
  localparam int tmo_cyc = 16;
`else
  localparam int tmo_cyc = 1024;
`endif
  logic clk = 1'b0;
  logic RESETN = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid, cmd_ready, cmd_we, wdat_valid, wdat_ready, rdat_valid, rdat_last, busy, err;
  logic [aw-1:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [dw-1:0] wdat, rdat;
  logic [dw/8-1:0] wdat_sel;
  logic ack_en = 1'b1, rnd_ack = 1'b0, wen = 1'b1, tk;
  wb_burst_master_if #(.dw(dw), .aw(aw)) bus();
  wb_burst_master #(.dw(dw), .aw(aw), .TIMEOUT_CYC(tmo_cyc)) dut (
    .wb_clk_i(clk), .RESETN(RESETN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdat_valid(wdat_valid), .wdat_ready(wdat_ready),
    .wdat(wdat), .wdat_sel(wdat_sel), .rdat_valid(rdat_valid), .rdat(rdat), .rdat_last(rdat_last),
    .busy(busy), .err(err), .wb(bus));
  function automatic logic [dw-1:0] rd_data(input logic [aw-1:0] a);
    return 32'hC0DE0000 ^ {6'd0, a};
  endfunction
  assign bus.wb_ack_i = bus.wb_stb_o && ack_en;
  assign bus.wb_dat_i = rd_data(bus.wb_addr_o);
  typedef struct {logic we; logic [aw-1:0] addr; logic [dw-1:0] dat; logic [dw/8-1:0] sel;} beat_t;
  typedef struct {logic [dw-1:0] dat; logic last;} rd_t;
  beat_t bq[$];
  rd_t rq[$];
  logic [dw/8+dw-1:0] wq[$];
  beat_t b;
  rd_t r;
  int n_chk = 0, n_fail = 0;
  int cyc_no = 0, acc_cyc, first_stb, last_ack, ready_rise, err_cyc, cyc_cnt, gap_cnt, ack_cnt, n_taken, err_seen = 0;
  logic prev_rd_ack = 1'b0, prev_ready = 1'b0, cyc_at_err = 1'b1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    cyc_no++;
    if (rdat_valid) begin
      check("rd_latency", prev_rd_ack, 1);
      if (rq.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        r = rq.pop_front();
        check("rdat", rdat, r.dat);
        check("rdat_last", rdat_last, r.last);
      end
    end
    prev_rd_ack = bus.wb_ack_i && !bus.wb_we_o;
    if (cmd_valid && cmd_ready) acc_cyc = cyc_no;
    if (bus.wb_cyc_o) cyc_cnt++;
    if (bus.wb_cyc_o && !bus.wb_stb_o) gap_cnt++;
    if (bus.wb_stb_o && first_stb < 0) first_stb = cyc_no;
    if (bus.wb_ack_i) begin
      ack_cnt++;
      last_ack = cyc_no;
      if (bq.size() == 0) check("bus_unexpected", 1, 0);
      else begin
        b = bq.pop_front();
        check("wb_addr", bus.wb_addr_o, b.addr);
        check("wb_we", bus.wb_we_o, b.we);
        check("wb_sel", bus.wb_sel_o, b.sel);
        if (b.we) check("wb_dat", bus.wb_dat_o, b.dat);
      end
    end
    if (cmd_ready && !prev_ready) ready_rise = cyc_no;
    prev_ready = cmd_ready;
    if (err) begin
      err_seen++;
      err_cyc = cyc_no;
      cyc_at_err = bus.wb_cyc_o;
    end
  end
  initial forever begin
    @(negedge clk);
    tk = wdat_valid && wdat_ready;
    @(posedge clk);
    if (tk) begin
      void'(wq.pop_front());
      n_taken++;
    end
    #2;
    wdat_valid = wen && wq.size() > 0;
    if (wq.size() > 0) {wdat_sel, wdat} = wq[0];
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ack) ack_en = $urandom_range(0, 2) != 0;
  end
  task automatic issue(input logic we, input logic [aw-1:0] a, input logic [7:0] len,
                       input logic [dw-1:0] wbase, input bit rnd_sel, input int extra);
    int n;
    logic [aw-1:0] x;
    logic [dw/8-1:0] s;
    @(posedge clk);
    #1;
    acc_cyc = -1; first_stb = -1; last_ack = -1; ready_rise = -1;
    cyc_cnt = 0; gap_cnt = 0; ack_cnt = 0; n_taken = 0;
    n = len == 8'd0 ? 1 : int'(len);
    x = a & ~aw'(3);
    for (int i = 0; i < n + extra; i++) begin
      s = rnd_sel ? 4'($urandom_range(1, 15)) : 4'hF;
      if (we) wq.push_back({s, wbase + dw'(i)});
      if (i < n) begin
        bq.push_back('{we, x, we ? wbase + dw'(i) : '0, we ? s : 4'hF});
        if (!we) rq.push_back('{rd_data(x), i == n - 1});
        x = x + aw'(4);
      end
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    #1;
    check("idle_reached", ok, 1);
  endtask
  initial begin
    cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0;
    wdat_valid = 0; wdat = '0; wdat_sel = '0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cyc", bus.wb_cyc_o, 0);
    check("rst_stb", bus.wb_stb_o, 0);
    check("rst_we", bus.wb_we_o, 0);
    check("rst_addr", bus.wb_addr_o, 0);
    check("rst_sel", bus.wb_sel_o, 0);
    check("rst_rdat_valid", rdat_valid, 0);
    check("rst_rdat_last", rdat_last, 0);
    check("rst_err", err, 0);
    check("rst_wdat_ready", wdat_ready, 0);
    @(posedge clk);
    #1 RESETN = 1'b1;
    issue(1'b1, 26'h100, 8'd4, 32'hA0, 0, 0);
    wait_idle();
    check("wr4_cyc_cycles", cyc_cnt, 4);
    check("wr4_acks", ack_cnt, 4);
    check("wr4_stb_rise", first_stb - acc_cyc, 1);
    check("wr4_ready_after_ack", ready_rise - last_ack, 2);
    check("wr4_drained", bq.size(), 0);
    issue(1'b0, 26'h3FFFFFC, 8'd2, '0, 0, 0);
    wait_idle();
    check("rd_wrap_acks", ack_cnt, 2);
    check("rd_wrap_cyc_cycles", cyc_cnt, 2);
    check("rd_wrap_drained", rq.size() + bq.size(), 0);
    check("rd_wrap_ready_after_ack", ready_rise - last_ack, 2);
    wen = 1'b1;
    issue(1'b1, 26'h200, 8'd3, 32'hB0, 0, 1);
    wen = 1'b0;
    repeat (5) @(posedge clk);
    #1 wen = 1'b1;
    wait_idle();
    check("gap_words_taken", n_taken, 3);
    check("gap_cycles", gap_cnt, 5);
    check("gap_acks", ack_cnt, 3);
    check("gap_drained", bq.size(), 0);
    check("gap_extra_left", wq.size(), 1);
    wq.delete();
    issue(1'b0, 26'h40, 8'd0, '0, 0, 0);
    wait_idle();
    check("len0_acks", ack_cnt, 1);
    check("len0_cyc_cycles", cyc_cnt, 1);
    check("len0_drained", rq.size(), 0);
    issue(1'b0, 26'h80, 8'd8, '0, 0, 0);
    for (int i = 0; i < 50 && ack_cnt < 2; i++) @(posedge clk);
    #2 RESETN = 1'b0;
    #1;
    check("async_rst_cyc", bus.wb_cyc_o, 0);
    check("async_rst_stb", bus.wb_stb_o, 0);
    check("async_rst_acks", ack_cnt, 2);
    bq.delete();
    rq.delete();
    @(negedge clk);
    RESETN = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    rnd_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      issue(1'($urandom_range(0, 1)), aw'($urandom), 8'($urandom_range(0, 6)), $urandom, 1, 0);
      wait_idle();
      check("rnd_drained", bq.size() + rq.size(), 0);
    end
    rnd_ack = 1'b0;
    @(posedge clk);
    #2 ack_en = 1'b1;
    wq.delete();
`ifdef WB_MST_TIMEOUT_EN
    ack_en = 1'b0;
    issue(1'b0, 26'h10, 8'd1, '0, 0, 0);
    wait_idle();
    check("tmo_err_pulses", err_seen, 1);
    check("tmo_err_delay", err_cyc - first_stb, 16);
    check("tmo_cyc_low", cyc_at_err, 0);
    check("tmo_no_rdat", rq.size(), 1);
    bq.delete();
    rq.delete();
    ack_en = 1'b1;
`else
    check("no_err_pulses", err_seen, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Emulation-side Wishbone master that sits directly upstream of the SDRAM controller's Wishbone slave port and generates its bus traffic. It accepts burst commands (address, length, direction) and streamed write data, and drives classic pipelined-free Wishbone cycles (CYC/STB/ACK) of up to 255 beats. Read data returns on a valid-only stream. It is synthesizable so that stimulus generation runs at emulator speed, with the transaction-level side feeding only commands and data.

## Interface
Parameters:
- `dw`, 32, Wishbone data width; byte-lane count is `dw/8`.
- `aw`, 26, Wishbone byte-address width.
- `TIMEOUT_CYC`, 1024, maximum cycles STB may wait for ACK; used only when the timeout feature is compiled in.

Ports:
- `wb_clk_i`  in  1  system clock; all logic is on its rising edge.
- `RESETN`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when both valid and ready are high.
- `cmd_we`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  aw  start byte address; low `log2(dw/8)` bits are forced to 0.
- `cmd_len`  in  8  beat count; 0 is treated as 1.
- `wdat_valid`  in  1  write word present.
- `wdat_ready`  out  1  write word accepted.
- `wdat`  in  dw  write data.
- `wdat_sel`  in  dw/8  write byte enables.
- `rdat_valid`  out  1  one-cycle read-beat pulse.
- `rdat`  out  dw  read data.
- `rdat_last`  out  1  marks the final beat of a read burst.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle pulse on timeout abort.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone control signals.
- `wb_addr_o`  out  aw  Wishbone address.
- `wb_dat_o`  out  dw  Wishbone write data.
- `wb_sel_o`  out  dw/8  Wishbone byte selects.
- `wb_ack_i`  in  1  slave acknowledge.
- `wb_dat_i`  in  dw  slave read data.

## Operation
- State machine has four states: IDLE, RUN, GAP and DONE.
  - IDLE: `cmd_ready`=1. On accept, latch direction, address and length into `beats_left` (9-bit; a length of 0 loads 1), then go to RUN.
  - RUN: `wb_cyc_o`=1 and `wb_stb_o`=1.
    - On each `wb_ack_i` while STB is high, `wb_addr_o` advances by `dw/8`. The address wraps modulo 2^aw.
    - `beats_left` decrements on each such ACK. When the last beat is acknowledged, go to DONE.
  - GAP (writes only): `wb_cyc_o`=1, `wb_stb_o`=0, entered when the write holding register is empty. Return to RUN when it fills.
  - DONE: CYC, STB and WE all 0 for exactly one cycle, then go to IDLE.
- Write path uses a one-entry holding register HR (data, sel, valid).
  - `wdat_ready` = write burst active && beats not yet loaded > 0 && (HR empty || ack on this cycle).
  - `wb_dat_o`/`wb_sel_o` are driven from HR.
  - In a write burst, STB is high only when HR is valid.
  - `wdat` words beyond the burst length are never accepted.
- Read path:
  - `wb_sel_o` is all-ones and `wb_we_o`=0.
  - On ACK, `rdat` is registered from `wb_dat_i`, `rdat_valid` pulses the next cycle, and `rdat_last` is set on the final beat.
  - The read stream has no backpressure.
- ACK while STB is low is ignored.
- Reset values: all outputs 0 except `cmd_ready`=1. State resets to IDLE and HR is emptied.
- Reset asserted mid-burst drops CYC and STB immediately (asynchronously). The partial burst is discarded.

## Timing
- Command accepted at edge N → CYC and STB high from cycle N+1.
- Zero-wait slave: an n-beat burst holds CYC for n cycles, followed by one DONE cycle. `cmd_ready` returns high 2 cycles after the final ACK.
- Minimum spacing between bursts is 1 idle cycle (DONE) plus 1 cycle back in IDLE.
- Read latency from ACK to `rdat_valid` is 1 cycle.
- Write: a word accepted at edge M can be on the bus in cycle M+1. With back-to-back ACKs and `wdat_valid` held high, throughput is 1 beat per cycle.

## Configuration
- `WB_MST_TIMEOUT_EN` defined:
  - A counter runs while STB is high and no ACK arrives.
  - Reaching `TIMEOUT_CYC` aborts the burst: go to DONE, pulse `err`, empty HR. For reads, `rdat_last` is not asserted.
  - The counter clears on every ACK and whenever STB is low.
- Not defined: the counter is not built, `err` is tied to 0, and the master waits indefinitely.

## Test plan
- Write burst, addr 0x100, len 4, zero-wait slave, `wdat` 0xA0..0xA3 always valid → addresses 0x100, 0x104, 0x108, 0x10C each acked once with the matching data; CYC high exactly 4 cycles; `cmd_ready` high 2 cycles after the last ACK.
- Read burst, addr 0x3FFFFFC, len 2 → second beat at address 0x0 (wrap); two `rdat_valid` pulses each 1 cycle after its ACK; `rdat_last` on the second only.
- Write len 3 with `wdat_valid` low for 5 cycles after the first word → GAP with CYC=1, STB=0 for those cycles; exactly 3 words consumed; a 4th offered word is not accepted.
- `cmd_len`=0 read → single beat, `rdat_last`=1.
- RESETN pulsed low mid-burst after 2 of 8 acks → CYC/STB drop without waiting for a clock; after release state is IDLE and `cmd_ready`=1.
- With `WB_MST_TIMEOUT_EN` and `TIMEOUT_CYC`=16, slave never acks → `err` pulses once 16 cycles after STB rises; CYC low the next cycle.
